// File: rtl/enigma_pkg.sv
// Shared types and constants for the enigma message sequencer.
package enigma_pkg;

  localparam int CHAR_W             = 8;
  localparam int DEFAULT_TIMEOUT    = 64;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    READY,
    ISSUE,
    WAIT,
    OUT
  } state_t;

endpackage

// File: rtl/enigma_char_fifo.sv
// Character buffer between the host and the sequencer, with a synchronous clear.
// full_next lets the owner register its ready flag one cycle ahead.
module enigma_char_fifo
  import enigma_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              push,
  input  logic [CHAR_W-1:0] push_data,
  input  logic              pop,
  output logic [CHAR_W-1:0] head,
  output logic              empty,
  output logic              full_next
);

  localparam int          AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CAP = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW + 1)'(1);

  logic [CHAR_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [AW:0]       count_next;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CAP);
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign head    = mem[rd_ptr];

  // Occupancy after this edge, also used to predict the full flag.
  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else begin
      if (do_push) count_next = count_next + ONE;
      if (do_pop)  count_next = count_next - ONE;
    end
    full_next = (count_next == CAP);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_next;
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Storage array; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/enigma_msg_ctrl.sv
// Message sequencer: buffers host characters, configures the enigma core,
// feeds it one character at a time under a watchdog and returns results.
module enigma_msg_ctrl
  import enigma_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_start,
  input  logic              cfg_dec,
  input  logic              in_valid,
  input  logic [CHAR_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [CHAR_W-1:0] out_data,
  input  logic              out_ready,
  output logic              core_set,
  output logic              core_en,
  output logic              core_valid,
  output logic [CHAR_W-1:0] core_din,
  output logic              core_dec,
  input  logic [CHAR_W-1:0] core_dout,
  input  logic              core_done,
  output logic              busy,
  output logic              err_timeout,
  output logic [CNT_W-1:0]  char_cnt
);

  localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state;
  state_t            next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_clear;
  logic              fifo_empty;
  logic              fifo_full_next;
  logic [CHAR_W-1:0] fifo_head;
  logic              timeout_hit;
  logic              in_ready_next;

  assign fifo_push  = in_valid && in_ready;
  assign fifo_clear = (state == SETUP);
  assign fifo_pop   = (state == READY) && !fifo_empty;

  enigma_char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (fifo_clear),
    .push      (fifo_push),
    .push_data (in_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full_next (fifo_full_next)
  );

  // Next-state decode; queued characters take priority over reconfiguration.
  always_comb begin
    next_state  = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE:  if (cfg_start) next_state = SETUP;
      SETUP: next_state = READY;
      READY: begin
        if (!fifo_empty)    next_state = ISSUE;
        else if (cfg_start) next_state = SETUP;
      end
      ISSUE: next_state = WAIT;
      WAIT: begin
        if (core_done) begin
          next_state = OUT;
        end else if (wait_cnt == WAIT_LAST) begin
          next_state  = READY;
          timeout_hit = 1'b1;
        end
      end
      OUT:     if (out_ready) next_state = READY;
      default: next_state = IDLE;
    endcase
    in_ready_next = (next_state != IDLE) && (next_state != SETUP) && !fifo_full_next;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Watchdog counter, restarted as each character leaves ISSUE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              wait_cnt <= '0;
    else if (state == ISSUE)   wait_cnt <= '0;
    else if (state == WAIT)    wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      core_set    <= 1'b0;
      core_en     <= 1'b0;
      core_valid  <= 1'b0;
      core_din    <= '0;
      core_dec    <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      char_cnt    <= '0;
    end else begin
      in_ready   <= in_ready_next;
      out_valid  <= (next_state == OUT);
      core_set   <= (next_state == SETUP);
      core_en    <= (next_state inside {READY, ISSUE, WAIT, OUT});
      core_valid <= (next_state == ISSUE);
      busy       <= (next_state inside {ISSUE, WAIT, OUT});
      if (next_state == SETUP)         core_dec <= cfg_dec;
      if (fifo_pop)                    core_din <= fifo_head;
      if (state == WAIT && core_done)  out_data <= core_dout;
      if (next_state == SETUP)         err_timeout <= 1'b0;
      else if (timeout_hit)            err_timeout <= 1'b1;
      if (next_state == SETUP)              char_cnt <= '0;
      else if (state == OUT && out_ready)   char_cnt <= char_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_enigma_msg_ctrl.sv
// Scoreboard bench for enigma_msg_ctrl driving a behavioural stub core.
module tb_enigma_msg_ctrl;

  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 64;
  localparam int CNT_W      = 2;
  localparam int STUB_LAT   = 5;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             cfg_start, cfg_dec, in_valid, out_ready;
  logic [7:0]       in_data;
  logic             in_ready, out_valid;
  logic [7:0]       out_data;
  logic             core_set, core_en, core_valid, core_dec;
  logic [7:0]       core_din, core_dout;
  logic             core_done;
  logic             busy, err_timeout;
  logic [CNT_W-1:0] char_cnt;

  int         tests_run = 0;
  int         tests_failed = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_val;
  int         delivered = 0;
  int         setup_pulses = 0;
  int         valid_pulses = 0;

  logic       stub_stall, stub_drop, stub_pend;
  int         stub_cd;
  logic [7:0] stub_data;

  always #5 clk = ~clk;

  enigma_msg_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_dec(cfg_dec),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .core_set(core_set), .core_en(core_en), .core_valid(core_valid),
    .core_din(core_din), .core_dec(core_dec), .core_dout(core_dout),
    .core_done(core_done), .busy(busy), .err_timeout(err_timeout),
    .char_cnt(char_cnt)
  );

  function automatic logic [7:0] rot13(input logic [7:0] c);
    if (c >= 8'h41 && c <= 8'h5A) return 8'((int'(c) - 65 + 13) % 26 + 65);
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] c, input bit expect_result);
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    checkOutput("push_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = c;
    if (expect_result) exp_q.push_back(rot13(c));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      tick();
      n++;
    end
    checkOutput(name, (exp_q.size() != 0 || busy), 0);
  endtask

  // Stub core: maps via ROT13 and raises done STUB_LAT cycles after a valid.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_done <= 1'b0;
      core_dout <= '0;
      stub_pend <= 1'b0;
      stub_cd   <= 0;
      stub_data <= '0;
    end else begin
      core_done <= 1'b0;
      if (core_valid) begin
        if (!stub_drop) begin
          stub_pend <= 1'b1;
          stub_cd   <= STUB_LAT - 1;
          stub_data <= rot13(core_din);
        end
      end else if (stub_pend && !stub_stall) begin
        if (stub_cd == 0) begin
          core_done <= 1'b1;
          core_dout <= stub_data;
          stub_pend <= 1'b0;
        end else begin
          stub_cd <= stub_cd - 1;
        end
      end
    end
  end

  // Scoreboard monitor: compares every accepted result against the queue.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      tests_run++;
      delivered++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_result: got 0x%0h, expected none", out_data);
      end else begin
        exp_val = exp_q.pop_front();
        if (out_data !== exp_val) begin
          tests_failed++;
          $display("[TB] FAIL result_data: got 0x%0h, expected 0x%0h", out_data, exp_val);
        end
      end
    end
  end

  // Pulse counters for the core strobes.
  always @(negedge clk) begin
    if (core_set)   setup_pulses++;
    if (core_valid) valid_pulses++;
  end

  // Hard stop in case the sequence stalls somewhere unbounded.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int sp, vp, d0, n;
    logic [CNT_W-1:0] cnt0;
    bit stable;
    cfg_start = 0; cfg_dec = 0; in_valid = 0; in_data = 0; out_ready = 1;
    stub_stall = 0; stub_drop = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_flags", {in_ready, out_valid, core_set, core_en, core_valid, core_dec, busy, err_timeout}, 0);
    checkOutput("reset_data", {out_data, core_din, 6'd0, char_cnt}, 0);
    @(negedge clk) reset_n = 1'b1;
    tick(); tick();
    checkOutput("idle_in_ready", in_ready, 0);

    // Basic configuration and one character.
    cfg_dec = 0; cfg_start = 1; tick(); cfg_start = 0;
    checkOutput("setup_core_set", core_set, 1);
    checkOutput("setup_core_en", core_en, 0);
    tick();
    checkOutput("ready_core_set", core_set, 0);
    checkOutput("ready_core_en", core_en, 1);
    checkOutput("ready_in_ready", in_ready, 1);
    checkOutput("setup_pulses", setup_pulses, 1);
    in_valid = 1; in_data = 8'h41; exp_q.push_back(8'h4E);
    tick(); in_valid = 0;
    checkOutput("issue_not_early", core_valid, 0);
    tick();
    checkOutput("issue_core_valid", core_valid, 1);
    checkOutput("issue_core_din", core_din, 8'h41);
    checkOutput("issue_busy", busy, 1);
    tick();
    checkOutput("issue_one_cycle", core_valid, 0);
    wait_drain("basic_drain");
    checkOutput("basic_char_cnt", char_cnt, 1);

    // FIFO fill while the core stalls.
    stub_stall = 1;
    for (int i = 0; i < 5; i++) applyStimulus(8'h41 + 8'(i), 1);
    checkOutput("fifo_full_in_ready", in_ready, 0);
    in_valid = 1; in_data = 8'h46; tick(); in_valid = 0;
    checkOutput("fifo_full_blocked", in_ready, 0);
    stub_stall = 0;
    wait_drain("fifo_drain");
    repeat (10) tick();
    checkOutput("fifo_char_cnt", char_cnt, 2);

    // Watchdog: first character dropped, second served normally.
    stub_drop = 1;
    in_valid = 1; in_data = 8'h41; tick();
    in_data = 8'h42; exp_q.push_back(8'h4F); tick(); in_valid = 0;
    checkOutput("to_core_valid", core_valid, 1);
    checkOutput("to_core_din", core_din, 8'h41);
    tick(); stub_drop = 0;
    repeat (TIMEOUT - 1) tick();
    checkOutput("to_err_before", err_timeout, 0);
    tick();
    checkOutput("to_err_at", err_timeout, 1);
    checkOutput("to_back_ready", busy, 0);
    wait_drain("to_drain");
    checkOutput("to_err_sticky", err_timeout, 1);
    checkOutput("to_char_cnt", char_cnt, 3);

    // Backpressure on the result port.
    out_ready = 0;
    applyStimulus(8'h43, 1);
    applyStimulus(8'h44, 1);
    n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
    checkOutput("bp_out_valid", out_valid, 1);
    cnt0 = char_cnt; vp = valid_pulses; stable = 1;
    repeat (10) begin
      tick();
      if (!out_valid || out_data !== 8'h50 || char_cnt !== cnt0) stable = 0;
    end
    checkOutput("bp_stable", stable, 1);
    checkOutput("bp_no_issue", valid_pulses - vp, 0);
    checkOutput("bp_cnt_held", char_cnt, 3);
    out_ready = 1; tick();
    checkOutput("bp_cnt_inc", char_cnt, 0);
    checkOutput("bp_valid_drop", out_valid, 0);
    wait_drain("bp_drain");
    checkOutput("bp_char_cnt", char_cnt, 1);

    // cfg_start in WAIT is ignored.
    stub_stall = 1;
    applyStimulus(8'h45, 1);
    repeat (3) tick();
    sp = setup_pulses;
    cfg_start = 1; tick(); cfg_start = 0; tick();
    checkOutput("cfg_ignored", setup_pulses - sp, 0);
    checkOutput("cfg_ignored_err", err_timeout, 1);
    stub_stall = 0;
    wait_drain("cfg_drain");
    checkOutput("cfg_char_cnt", char_cnt, 2);

    // Reconfigure in decrypt mode and wrap the 2-bit counter.
    cfg_dec = 1; cfg_start = 1; tick(); cfg_start = 0; cfg_dec = 0;
    checkOutput("re_core_dec", core_dec, 1);
    checkOutput("re_char_cnt", char_cnt, 0);
    checkOutput("re_err_clear", err_timeout, 0);
    tick();
    d0 = delivered;
    for (int i = 0; i < 4; i++) applyStimulus(8'h4E + 8'(i), 1);
    wait_drain("wrap_drain");
    checkOutput("wrap_delivered", delivered - d0, 4);
    checkOutput("wrap_char_cnt", char_cnt, 0);

    // Asynchronous reset in WAIT.
    stub_stall = 1;
    applyStimulus(8'h46, 0);
    repeat (3) tick();
    checkOutput("rst_busy_before", busy, 1);
    #2 reset_n = 0;
    #1;
    checkOutput("rst_async_flags", {in_ready, out_valid, core_set, core_en, core_valid, core_dec, busy, err_timeout}, 0);
    checkOutput("rst_async_data", {out_data, core_din, 6'd0, char_cnt}, 0);
    stub_stall = 0;
    @(negedge clk) reset_n = 1'b1;
    repeat (3) tick();
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
